// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one fixed-latency, single-ported memory between the instruction
//   fetch path (IF) and the load/store path (LS). Only one access is in flight
//   at a time. Simultaneous requests are arbitrated round-robin.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   if_req/if_addr     fetch request (level) and address
//   if_gnt/if_rvalid   one-cycle pulses: fetch accepted / fetch data valid
//   if_rdata           fetched instruction
//   ls_req/ls_we/ls_be load/store request (level), store flag, byte enables
//   ls_addr/ls_wdata   data address and store data
//   ls_gnt/ls_rvalid   one-cycle pulses: LS accepted / load data or store ack
//   ls_rdata           load data (0 for stores)
//   mem_en/mem_we      one-cycle access strobe, write strobe
//   mem_be/mem_addr    byte enables and address to memory
//   mem_wdata          write data to memory
//   mem_rdata          read data, valid MEM_LAT cycles after the mem_en cycle
//   busy               high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [3:0]        ls_be,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   typedef enum logic       {OWN_IF, OWN_LS}          owner_t;

   localparam logic [3:0] LP_LAT = 4'(MEM_LAT);

   state_t              r_state,      w_state;
   owner_t              r_owner,      w_owner;
   owner_t              r_last_owner, w_last_owner;
   logic [3:0]          r_cnt,        w_cnt;
   logic                r_if_gnt,     w_if_gnt;
   logic                r_ls_gnt,     w_ls_gnt;
   logic                r_if_rvalid,  w_if_rvalid;
   logic                r_ls_rvalid,  w_ls_rvalid;
   logic [DATA_W-1:0]   r_if_rdata,   w_if_rdata;
   logic [DATA_W-1:0]   r_ls_rdata,   w_ls_rdata;
   logic                r_mem_en,     w_mem_en;
   logic                r_mem_we,     w_mem_we;
   logic [3:0]          r_mem_be,     w_mem_be;
   logic [ADDR_W-1:0]   r_mem_addr,   w_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata,  w_mem_wdata;
   logic                r_busy,       w_busy;
   logic                w_win_ls;

   always_comb begin
      w_state      = r_state;
      w_owner      = r_owner;
      w_last_owner = r_last_owner;
      w_cnt        = r_cnt;
      w_if_gnt     = 1'b0;
      w_ls_gnt     = 1'b0;
      w_if_rvalid  = 1'b0;
      w_ls_rvalid  = 1'b0;
      w_if_rdata   = r_if_rdata;
      w_ls_rdata   = r_ls_rdata;
      w_mem_en     = 1'b0;
      w_mem_we     = r_mem_we;
      w_mem_be     = r_mem_be;
      w_mem_addr   = r_mem_addr;
      w_mem_wdata  = r_mem_wdata;
      w_win_ls     = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (if_req || ls_req) begin
               // On a tie the requester that did not own the last access wins.
               w_win_ls     = ls_req && (!if_req || (r_last_owner == OWN_IF));
               w_owner      = w_win_ls ? OWN_LS : OWN_IF;
               w_last_owner = w_owner;
               w_mem_en     = 1'b1;
               w_cnt        = LP_LAT;
               w_state      = S_WAIT;
               if (w_win_ls) begin
                  w_ls_gnt    = 1'b1;
                  w_mem_we    = ls_we;
                  w_mem_be    = ls_be;
                  w_mem_addr  = ls_addr;
                  w_mem_wdata = ls_wdata;
               end else begin
                  w_if_gnt    = 1'b1;
                  w_mem_we    = 1'b0;
                  w_mem_be    = 4'hF;
                  w_mem_addr  = if_addr;
                  w_mem_wdata = '0;
               end
            end
         end
         S_WAIT: begin
            // The counter holds during the strobe cycle so that read data is
            // taken exactly MEM_LAT cycles after mem_en.
            if (!r_mem_en) begin
               w_cnt = r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  w_state = S_RESP;
                  if (r_owner == OWN_LS) begin
                     w_ls_rvalid = 1'b1;
                     w_ls_rdata  = r_mem_we ? '0 : mem_rdata;
                  end else begin
                     w_if_rvalid = 1'b1;
                     w_if_rdata  = mem_rdata;
                  end
               end
            end
         end
         S_RESP:  w_state = S_IDLE;
         default: w_state = S_IDLE;
      endcase

      w_busy = (w_state != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= OWN_IF;
         r_last_owner <= OWN_LS;
         r_cnt        <= '0;
         r_if_gnt     <= 1'b0;
         r_ls_gnt     <= 1'b0;
         r_if_rvalid  <= 1'b0;
         r_ls_rvalid  <= 1'b0;
         r_if_rdata   <= '0;
         r_ls_rdata   <= '0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_be     <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_owner      <= w_owner;
         r_last_owner <= w_last_owner;
         r_cnt        <= w_cnt;
         r_if_gnt     <= w_if_gnt;
         r_ls_gnt     <= w_ls_gnt;
         r_if_rvalid  <= w_if_rvalid;
         r_ls_rvalid  <= w_ls_rvalid;
         r_if_rdata   <= w_if_rdata;
         r_ls_rdata   <= w_ls_rdata;
         r_mem_en     <= w_mem_en;
         r_mem_we     <= w_mem_we;
         r_mem_be     <= w_mem_be;
         r_mem_addr   <= w_mem_addr;
         r_mem_wdata  <= w_mem_wdata;
         r_busy       <= w_busy;
      end
   end

   assign if_gnt    = r_if_gnt;
   assign ls_gnt    = r_ls_gnt;
   assign if_rvalid = r_if_rvalid;
   assign ls_rvalid = r_ls_rvalid;
   assign if_rdata  = r_if_rdata;
   assign ls_rdata  = r_ls_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_be    = r_mem_be;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = r_busy;

endmodule
